// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with valid/ready handshakes on both sides.
// Define ALU_SEQ_MUL_EN to build opcode 9 (MUL) as an iterative shift-add unit.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             illegal
);
  localparam int unsigned SHW = $clog2(WIDTH);

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
`else
  typedef enum logic [0:0] {StIdle, StDone} state_e;
`endif

  state_e state_q, state_d;
  logic   accept, load_res;

  logic [WIDTH-1:0] result_q, res_d, alu_res;
  logic             carry_q, zero_q, neg_q, ovf_q, illegal_q;
  logic             carry_d, ovf_d, ill_d, alu_carry, alu_ovf, alu_ill;

  logic [WIDTH:0]   sum, diff, shl_full, shr_full;
  logic signed [WIDTH:0] asr_full;
  logic [31:0]      sh32, sh_rot;
  logic [WIDTH-1:0] rol;

  assign accept = in_valid & in_ready;

`ifdef ALU_SEQ_MUL_EN
  localparam int unsigned CW = $clog2(WIDTH + 1);
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH:0]     psum;
  logic               start_mul, mul_last, mul_done;

  assign start_mul = accept & (op == 4'd9);
  assign mul_last  = cnt_q == CW'(WIDTH);
  assign mul_done  = (state_q == StBusy) & mul_last;
  assign psum      = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);

  // Product starts as {0, b}; each step conditionally adds a into the high half and shifts right.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (start_mul) begin
      mcand_q <= a;
      prod_q  <= {{WIDTH{1'b0}}, b};
      cnt_q   <= '0;
    end else if ((state_q == StBusy) && !mul_last) begin
      prod_q <= {psum, prod_q[WIDTH-1:1]};
      cnt_q  <= cnt_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StDone;
`ifdef ALU_SEQ_MUL_EN
      StBusy:  if (mul_last) state_d = StDone;
`endif
      StDone:  if (out_ready) state_d = in_valid ? StDone : StIdle;
      default: state_d = StIdle;
    endcase
`ifdef ALU_SEQ_MUL_EN
    if (start_mul) state_d = StBusy;
`endif
  end

  // in_ready is held low during reset so operands presented under reset are never taken.
  always_comb begin
    in_ready  = ~rst & ((state_q == StIdle) | ((state_q == StDone) & out_ready));
    out_valid = state_q == StDone;
`ifdef ALU_SEQ_MUL_EN
    load_res  = (accept & (op != 4'd9)) | mul_done;
`else
    load_res  = accept;
`endif
  end

  assign sum      = {1'b0, a} + {1'b0, b};
  assign diff     = {1'b0, a} - {1'b0, b};
  assign sh32     = 32'(b[SHW-1:0]);
  assign shl_full = {1'b0, a} << sh32;
  assign shr_full = {a, 1'b0} >> sh32;
  assign asr_full = $signed({a, 1'b0}) >>> sh32;
  // Rotation is modulo WIDTH; sh is always below 2*WIDTH so one subtraction suffices.
  assign sh_rot   = (sh32 >= WIDTH) ? sh32 - WIDTH : sh32;
  assign rol      = (a << sh_rot) | (a >> (WIDTH - sh_rot));

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_ill   = 1'b0;
    case (op)
      4'd0: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];
        alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2:  alu_res = a & b;
      4'd3:  alu_res = a | b;
      4'd4:  alu_res = a ^ b;
      4'd5:  alu_res = ~(a ^ b);
      4'd6: begin
        alu_res   = shl_full[WIDTH-1:0];
        alu_carry = shl_full[WIDTH];
      end
      4'd7: begin
        alu_res   = shr_full[WIDTH:1];
        alu_carry = shr_full[0];
      end
      4'd8: begin
        alu_res   = asr_full[WIDTH:1];
        alu_carry = asr_full[0];
      end
      4'd10:   alu_res = rol;
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    res_d   = alu_res;
    carry_d = alu_carry;
    ovf_d   = alu_ovf;
    ill_d   = alu_ill;
`ifdef ALU_SEQ_MUL_EN
    if (mul_done) begin
      res_d   = prod_q[WIDTH-1:0];
      carry_d = |prod_q[2*WIDTH-1:WIDTH];
      ovf_d   = 1'b0;
      ill_d   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q  <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else if (load_res) begin
      result_q  <= res_d;
      carry_q   <= carry_d;
      zero_q    <= res_d == '0;
      neg_q     <= res_d[WIDTH-1];
      ovf_q     <= ovf_d;
      illegal_q <= ill_d;
    end
  end

  assign result  = result_q;
  assign carry   = carry_q;
  assign zero    = zero_q;
  assign neg     = neg_q;
  assign ovf     = ovf_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: WIDTH=8 and WIDTH=6 instances against an arithmetic model.
// Honours ALU_SEQ_MUL_EN the same way as the design.
module tb_alu_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ALU_SEQ_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic       rst, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, result;
  logic [3:0] op;
  logic       carry, zero, neg, ovf, illegal;
  logic [12:0] obs8;
  assign obs8 = {result, carry, zero, neg, ovf, illegal};

  logic       in_valid6, in_ready6, out_valid6, out_ready6;
  logic [5:0] a6, b6, result6;
  logic [3:0] op6;
  logic       carry6, zero6, neg6, ovf6, illegal6;
  logic [10:0] obs6;
  assign obs6 = {result6, carry6, zero6, neg6, ovf6, illegal6};

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .carry(carry), .zero(zero),
    .neg(neg), .ovf(ovf), .illegal(illegal)
  );

  alu_seq #(.WIDTH(6)) dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid6), .in_ready(in_ready6), .a(a6), .b(b6), .op(op6),
    .out_valid(out_valid6), .out_ready(out_ready6), .result(result6), .carry(carry6),
    .zero(zero6), .neg(neg6), .ovf(ovf6), .illegal(illegal6)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  function automatic longint sval(input longint unsigned v, input int w);
    if (((v >> (w - 1)) & 64'd1) != 0) return longint'(v) - (longint'(1) << w);
    return longint'(v);
  endfunction

  function automatic void ref_alu(input int w, input longint unsigned x, input longint unsigned y,
                                  input int opc, output longint unsigned r, output logic c,
                                  output logic z, output logic n, output logic v, output logic il);
    longint unsigned mask;
    longint hi, lo, sx, sr;
    int sh, rot;
    mask = (64'd1 << w) - 64'd1;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    sx = sval(x, w);
    sh = int'(y & 64'd7);  // both widths under test use a 3-bit shift amount
    r = 0; c = 0; v = 0; il = 0;
    case (opc)
      0: begin
        r = (x + y) & mask; c = ((x + y) >> w) != 0;
        sr = sx + sval(y, w); v = (sr > hi) || (sr < lo);
      end
      1: begin
        r = (x - y) & mask; c = x < y;
        sr = sx - sval(y, w); v = (sr > hi) || (sr < lo);
      end
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = ~(x ^ y) & mask;
      6: begin
        r = (x << sh) & mask;
        c = (sh != 0 && sh <= w) ? (((x >> (w - sh)) & 64'd1) != 0) : 1'b0;
      end
      7: begin
        r = x >> sh;
        c = (sh != 0) ? (((x >> (sh - 1)) & 64'd1) != 0) : 1'b0;
      end
      8: begin
        r = 64'(sx >>> sh) & mask;
        c = (sh != 0) ? ((64'(sx >>> (sh - 1)) & 64'd1) != 0) : 1'b0;
      end
      9: begin
        if (MulEn) begin
          r = (x * y) & mask; c = ((x * y) >> w) != 0;
        end else il = 1;
      end
      10: begin
        rot = sh % w;
        r = ((x << rot) | (x >> (w - rot))) & mask;
      end
      default: il = 1;
    endcase
    z = r == 0;
    n = ((r >> (w - 1)) & 64'd1) != 0;
  endfunction

  function automatic logic [12:0] exp8(input logic [7:0] x, input logic [7:0] y,
                                       input logic [3:0] o);
    longint unsigned r;
    logic c, z, n, v, il;
    ref_alu(8, 64'(x), 64'(y), int'(o), r, c, z, n, v, il);
    return {r[7:0], c, z, n, v, il};
  endfunction

  function automatic logic [10:0] exp6(input logic [5:0] x, input logic [5:0] y,
                                       input logic [3:0] o);
    longint unsigned r;
    logic c, z, n, v, il;
    ref_alu(6, 64'(x), 64'(y), int'(o), r, c, z, n, v, il);
    return {r[5:0], c, z, n, v, il};
  endfunction

  function automatic int exp_lat(input logic [3:0] o, input int w);
    return (MulEn && o == 4'd9) ? w + 1 : 1;
  endfunction

  // ---------------- drivers ----------------
  task automatic settle();
    in_valid = 0; in_valid6 = 0; out_ready = 1; out_ready6 = 1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Present one operand set, wait for acceptance, then count clocks until out_valid.
  task automatic run_op8(input logic [7:0] x, input logic [7:0] y, input logic [3:0] o,
                         output int lat);
    int n = 0;
    a = x; b = y; op = o; in_valid = 1;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic run_op6(input logic [5:0] x, input logic [5:0] y, input logic [3:0] o,
                         output int lat);
    int n = 0;
    a6 = x; b6 = y; op6 = o; in_valid6 = 1;
    while (!in_ready6 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid6 = 0;
    lat = 1;
    while (!out_valid6 && lat < 60) begin @(posedge clk); #1; lat++; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; in_valid = 1; in_valid6 = 1; out_ready = 1; out_ready6 = 1;
    a = 8'h5A; b = 8'h33; op = 4'd0; a6 = 6'h15; b6 = 6'h2A; op6 = 4'd0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, obs8} !== 15'h0) begin
        errors++;
        $display("FAIL reset_cycle%0d: got %h want 0", i, {out_valid, in_ready, obs8});
      end
    end
    checks++;
    if ({out_valid6, in_ready6, obs6} !== 13'h0) begin
      errors++;
      $display("FAIL reset_w6: got %h want 0", {out_valid6, in_ready6, obs6});
    end
    rst = 0; in_valid = 0; in_valid6 = 0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b want 1", in_ready);
    end
  endtask

  task automatic test_arith();
    int lat;
    logic [7:0] x, y;
    logic [3:0] o;
    settle();
    run_op8(8'hF0, 8'h20, 4'd0, lat);
    checks++;
    if ({lat == 1, obs8} !== {1'b1, 8'h10, 5'b10000}) begin
      errors++;
      $display("FAIL add_f0_20: got lat=%0d %h want lat=1 %h", lat, obs8, {8'h10, 5'b10000});
    end
    run_op8(8'h80, 8'h01, 4'd1, lat);
    checks++;
    if ({lat == 1, obs8} !== {1'b1, 8'h7F, 5'b00010}) begin
      errors++;
      $display("FAIL sub_80_01: got lat=%0d %h want lat=1 %h", lat, obs8, {8'h7F, 5'b00010});
    end
    for (int i = 0; i < 20; i++) begin
      x = 8'($urandom); y = 8'($urandom); o = 4'($urandom_range(0, 1));
      run_op8(x, y, o, lat);
      checks++;
      if (obs8 !== exp8(x, y, o)) begin
        errors++;
        $display("FAIL addsub op=%0d a=%h b=%h: got %h want %h", o, x, y, obs8, exp8(x, y, o));
      end
    end
  endtask

  task automatic test_backpressure();
    settle();
    out_ready = 0;
    a = 8'h01; b = 8'h01; op = 4'd0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, in_ready, obs8} !== {2'b10, 8'h02, 5'b00000}) begin
        errors++;
        $display("FAIL hold_cycle%0d: got %h want %h", i, {out_valid, in_ready, obs8},
                 {2'b10, 8'h02, 5'b00000});
      end
      @(posedge clk); #1;
    end
    a = 8'hFF; b = 8'hFF; op = 4'd4; in_valid = 1; out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 0;
    checks++;
    if ({out_valid, obs8} !== {1'b1, 8'h00, 5'b01000}) begin
      errors++;
      $display("FAIL queued_xor: got %h want %h", {out_valid, obs8}, {1'b1, 8'h00, 5'b01000});
    end
  endtask

  task automatic test_shifts();
    int lat;
    logic [7:0] x, y;
    logic [5:0] x6, y6;
    logic [3:0] o;
    logic [3:0] shops [4] = '{4'd6, 4'd7, 4'd8, 4'd10};
    settle();
    run_op8(8'h81, 8'h01, 4'd6, lat);
    checks++;
    if (obs8 !== {8'h02, 5'b10000}) begin
      errors++;
      $display("FAIL shl_81_1: got %h want %h", obs8, {8'h02, 5'b10000});
    end
    run_op8(8'h90, 8'h02, 4'd8, lat);
    checks++;
    if (obs8 !== {8'hE4, 5'b00100}) begin
      errors++;
      $display("FAIL asr_90_2: got %h want %h", obs8, {8'hE4, 5'b00100});
    end
    run_op6(6'h3F, 6'h07, 4'd7, lat);
    checks++;
    if (obs6 !== {6'h00, 5'b01000}) begin
      errors++;
      $display("FAIL w6_shr_3f_7: got %h want %h", obs6, {6'h00, 5'b01000});
    end
    for (int i = 0; i < 30; i++) begin
      x = 8'($urandom); y = 8'($urandom); o = shops[$urandom_range(0, 3)];
      run_op8(x, y, o, lat);
      checks++;
      if (obs8 !== exp8(x, y, o)) begin
        errors++;
        $display("FAIL shift op=%0d a=%h b=%h: got %h want %h", o, x, y, obs8, exp8(x, y, o));
      end
      x6 = 6'($urandom); y6 = 6'($urandom); o = shops[$urandom_range(0, 3)];
      run_op6(x6, y6, o, lat);
      checks++;
      if (obs6 !== exp6(x6, y6, o)) begin
        errors++;
        $display("FAIL w6_shift op=%0d a=%h b=%h: got %h want %h", o, x6, y6, obs6,
                 exp6(x6, y6, o));
      end
    end
  endtask

  task automatic test_mul();
    int lat;
    settle();
`ifdef ALU_SEQ_MUL_EN
    int seen = 0;
    run_op8(8'h10, 8'h11, 4'd9, lat);
    checks++;
    if ({lat == 9, obs8} !== {1'b1, 8'h10, 5'b10000}) begin
      errors++;
      $display("FAIL mul_10_11: got lat=%0d %h want lat=9 %h", lat, obs8, {8'h10, 5'b10000});
    end
    settle();
    a = 8'h37; b = 8'hC5; op = 4'd9; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    #1;
    checks++;
    if ({in_ready, obs8} !== {1'b1, 13'h0}) begin
      errors++;
      $display("FAIL mul_abort_state: got %h want %h", {in_ready, obs8}, {1'b1, 13'h0});
    end
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL mul_abort_valid: got %0d valid cycles want 0", seen);
    end
`else
    run_op8(8'h10, 8'h11, 4'd9, lat);
    checks++;
    if ({lat == 1, obs8} !== {1'b1, 8'h00, 5'b01001}) begin
      errors++;
      $display("FAIL mul_disabled: got lat=%0d %h want lat=1 %h", lat, obs8, {8'h00, 5'b01001});
    end
`endif
  endtask

  task automatic test_illegal();
    int lat;
    settle();
    run_op8(8'hA5, 8'h3C, 4'd12, lat);
    checks++;
    if ({lat == 1, obs8} !== {1'b1, 8'h00, 5'b01001}) begin
      errors++;
      $display("FAIL illegal_12: got lat=%0d %h want lat=1 %h", lat, obs8, {8'h00, 5'b01001});
    end
    run_op6(6'h2B, 6'h11, 4'd15, lat);
    checks++;
    if ({lat == 1, obs6} !== {1'b1, 6'h00, 5'b01001}) begin
      errors++;
      $display("FAIL w6_illegal_15: got lat=%0d %h want lat=1 %h", lat, obs6, {6'h00, 5'b01001});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] xs [8];
    logic [7:0] ys [8];
    logic [3:0] os [8];
    settle();
    for (int i = 0; i < 8; i++) begin
      xs[i] = 8'($urandom); ys[i] = 8'($urandom); os[i] = 4'($urandom_range(0, 8));
    end
    a = xs[0]; b = ys[0]; op = os[0]; in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, obs8} !== {1'b1, exp8(xs[i], ys[i], os[i])}) begin
        errors++;
        $display("FAIL b2b_%0d: got %h want %h", i, {out_valid, obs8},
                 {1'b1, exp8(xs[i], ys[i], os[i])});
      end
      if (i < 7) begin
        a = xs[i + 1]; b = ys[i + 1]; op = os[i + 1];
      end else begin
        in_valid = 0;
      end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [7:0] x, y;
    logic [5:0] x6, y6;
    logic [3:0] o;
    settle();
    for (int i = 0; i < 150; i++) begin
      x = 8'($urandom); y = 8'($urandom); o = 4'($urandom_range(0, 15));
      run_op8(x, y, o, lat);
      checks++;
      if ({lat, obs8} !== {exp_lat(o, 8), exp8(x, y, o)}) begin
        errors++;
        $display("FAIL rand op=%0d a=%h b=%h: got lat=%0d %h want lat=%0d %h", o, x, y, lat,
                 obs8, exp_lat(o, 8), exp8(x, y, o));
      end
    end
    for (int i = 0; i < 60; i++) begin
      x6 = 6'($urandom); y6 = 6'($urandom); o = 4'($urandom_range(0, 15));
      run_op6(x6, y6, o, lat);
      checks++;
      if ({lat, obs6} !== {exp_lat(o, 6), exp6(x6, y6, o)}) begin
        errors++;
        $display("FAIL w6_rand op=%0d a=%h b=%h: got lat=%0d %h want lat=%0d %h", o, x6, y6,
                 lat, obs6, exp_lat(o, 6), exp6(x6, y6, o));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; in_valid = 0; out_ready = 1; a = '0; b = '0; op = '0;
    in_valid6 = 0; out_ready6 = 1; a6 = '0; b6 = '0; op6 = '0;
    test_reset();
    test_arith();
    test_backpressure();
    test_shifts();
    test_mul();
    test_illegal();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
